spi_flash_target: RTL and testbench
===================================

# spi_flash_target

SPI-bus responder that emulates the read side of a serial NOR flash, the other end of the SPI flash controller. Samples the controller's `o_cs`/`o_sclk`/`o_copi` lines in its own clock domain and answers READ (03h), READ STATUS (05h) and JEDEC ID (9Fh) from a byte-wide internal memory. A host-side write port preloads that memory. It serves as a synthesizable loopback target on a second pad set, and as the bench model for the controller.

## Interface
- `MEM_DEPTH`, 256: bytes of backing memory; power of two, 16..4096.
- `JEDEC_ID`, 24'hC84015: three bytes returned by 9Fh, MSB first.
- `STATUS`, 8'h00: byte returned by 05h.
- `i_clk` in 1: system clock. One clock; all logic on its rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_cs` in 1: SPI chip select, active low; asynchronous to `i_clk`.
- `i_sclk` in 1: SPI clock, mode 0; asynchronous.
- `i_copi` in 1: controller-out data; asynchronous.
- `o_cipo` out 1: target-out data.
- `o_cipo_oe` out 1: pad output enable; high only while in the DATA state.
- `i_wr` in 1: host write strobe, one byte per cycle.
- `i_waddr` in log2(MEM_DEPTH): host write address.
- `i_wdata` in 8: host write data.
- `o_cmd` out 8: last command byte received (observation).
- `o_active` out 1: synchronized chip-select asserted.

## Operation
- Inputs `i_cs`, `i_sclk` and `i_copi` each pass through a 2-flop synchronizer plus a third history flop. `sck_rise`/`sck_fall` and `cs_fall`/`cs_rise` are single-cycle strobes decoded from stages 2 and 3.
- Data is MSB first. COPI is sampled (synchronized copy) on `sck_rise`. CIPO is updated on `sck_fall`.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: entered on reset or `cs_rise` from any state.
  - IDLE to CMD: on `cs_fall`; clears the 3-bit bit counter.
  - CMD: after 8 rising edges, latch `o_cmd`, then branch:
    - 03h to ADDR; clear the 2-bit byte counter.
    - 05h to DATA; load `STATUS` into tx shift.
    - 9Fh to DATA; load `JEDEC_ID[23:16]`, id index = 1.
    - Any other value to IGNORE.
  - ADDR: shift 24 bits into the address register. Only the low log2(MEM_DEPTH) bits are kept; higher bits are ignored. On the 24th rising edge, issue a memory read of that address and go to DATA.
  - DATA: on each `sck_fall`, drive tx_shift[7] onto `o_cipo` and shift left. On the 8th rising edge of each byte, load the next byte:
    - 03h: memory at address+1; the address wraps modulo MEM_DEPTH.
    - 05h: `STATUS` repeats.
    - 9Fh: `JEDEC_ID` bytes 2, 3, then 00h forever.
  - IGNORE: `o_cipo_oe`=0 until `cs_rise`.
- Memory: synchronous 1-cycle read, read-first. A host write and an SPI read of the same address in the same cycle return the old byte. A host write while a DATA byte is in flight is allowed and affects only later loads.
- COPI bits received during DATA are ignored.
- Reset values: `o_cipo`=0, `o_cipo_oe`=0, `o_cmd`=00h, `o_active`=0, state IDLE, synchronizers cleared to CS-high/SCK-low. Memory contents are not reset.
- `i_rst` mid-transfer returns to IDLE. Because the synchronizer is reset to CS high, a still-asserted CS causes a new `cs_fall` 2 cycles after reset releases. The bench must not rely on resuming a transfer.

## Timing
- Synchronizer latency: a pin edge produces a strobe 3 `i_clk` cycles later, giving ±1 cycle of sampling uncertainty.
- `o_cipo` changes 3–4 cycles after a pin SCK falling edge.
- Each SCK high and each SCK low phase must be ≥4 `i_clk` periods, so SCK ≤ i_clk/8. Slower SCK is unlimited.
- CS setup to the first SCK rise ≥4 cycles. CS hold after the last SCK fall ≥4 cycles.
- First data bit:
  - The tx byte is loaded on the 8th/24th rising edge.
  - The memory read completes 1 cycle later, well before the next `sck_fall`.
  - The MSB appears after that fall and before the first data-phase rise.
- `o_cipo_oe` rises on the cycle DATA is entered and falls on the cycle after `cs_rise` is detected.

## Test plan
- JEDEC: CS low, send 9Fh, clock 32 bits -> controller reads C8h, 40h, 15h, 00h; `o_cmd`=9Fh.
- READ: preload mem[i]=i^A5h. Send 03h 00 00 FE and read 4 bytes -> 5Bh, 5Ah, A5h, A4h, showing the wrap from FFh to 00h.
- Status/unknown: send 05h and read 2 bytes -> 00h, 00h. Send 0Bh -> `o_cipo_oe` stays 0 for 32 clocks; `o_cmd`=0Bh.
- Abort: raise CS after 12 bits of address, then issue 03h 00 00 10 -> returns mem[10h]; no state leaks from the aborted transfer.
- Collision: host writes mem[20h]=77h in the same cycle as the SPI read load of 20h -> the old value is returned; a re-read returns 77h.
- Reset mid-DATA: assert `i_rst` for 1 cycle -> `o_cipo_oe`=0 and `o_cipo`=0 next cycle. After CS toggles high then low, a new 9Fh transfer succeeds.

Source files
------------

// File: rtl/spi_flash_target.sv
// spi_flash_target: SPI-bus responder emulating the read side of a serial NOR
// flash. Pins are oversampled in the i_clk domain; answers READ (03h),
// READ STATUS (05h) and JEDEC ID (9Fh) from a host-preloadable byte memory.
module spi_flash_target #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [23:0] JEDEC_ID  = 24'hC84015,
    parameter logic [7:0]  STATUS    = 8'h00
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cs,
    input  logic                         i_sclk,
    input  logic                         i_copi,
    output logic                         o_cipo,
    output logic                         o_cipo_oe,
    input  logic                         i_wr,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
    input  logic [7:0]                   i_wdata,
    output logic [7:0]                   o_cmd,
    output logic                         o_active
);

    localparam int            AW       = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_IGNORE
    } state_t;

    // Synchronizer chains: [0],[1] are the 2-flop synchronizer, [2] is history
    logic [2:0] r_cs_sync;
    logic [2:0] r_sck_sync;
    logic [2:0] r_copi_sync;

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_copi_bit;

    state_t        r_state,     w_state_next;
    logic [2:0]    r_bit_cnt,   w_bit_cnt_next;
    logic [1:0]    r_byte_cnt,  w_byte_cnt_next;
    logic [7:0]    r_cmd,       w_cmd_next;
    logic [6:0]    r_rx_shift,  w_rx_shift_next;
    logic [AW-1:0] r_addr,      w_addr_next;
    logic [7:0]    r_tx_shift,  w_tx_shift_next;
    logic [1:0]    r_id_idx,    w_id_idx_next;
    logic          r_cipo,      w_cipo_next;
    logic          r_active;
    logic          r_rd_pending;
    logic [7:0]    r_rd_data;
    logic [7:0]    w_rx_byte;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;

    logic [7:0]    r_mem [MEM_DEPTH];

    // Oversample the asynchronous pins; reset to the idle bus (CS high, SCK low)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_sync   <= 3'b111;
            r_sck_sync  <= 3'b000;
            r_copi_sync <= 3'b000;
        end else begin
            r_cs_sync   <= {r_cs_sync[1:0],   i_cs};
            r_sck_sync  <= {r_sck_sync[1:0],  i_sclk};
            r_copi_sync <= {r_copi_sync[1:0], i_copi};
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    // COPI taken from the history stage so it lines up with the SCK strobe
    assign w_copi_bit = r_copi_sync[2];
    assign w_rx_byte  = {r_rx_shift, w_copi_bit};

    // Byte memory: host write port plus read-first synchronous read for SPI
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_cmd        <= 8'h00;
            r_rx_shift   <= 7'd0;
            r_addr       <= '0;
            r_tx_shift   <= 8'h00;
            r_id_idx     <= 2'd0;
            r_cipo       <= 1'b0;
            r_active     <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_cmd        <= w_cmd_next;
            r_rx_shift   <= w_rx_shift_next;
            r_addr       <= w_addr_next;
            r_tx_shift   <= w_tx_shift_next;
            r_id_idx     <= w_id_idx_next;
            r_cipo       <= w_cipo_next;
            r_active     <= ~r_cs_sync[1];
            r_rd_pending <= w_rd_en;
        end
    end

    // Next-state, shift and memory-read decode
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_cnt_next = r_byte_cnt;
        w_cmd_next      = r_cmd;
        w_rx_shift_next = r_rx_shift;
        w_addr_next     = r_addr;
        w_tx_shift_next = r_tx_shift;
        w_id_idx_next   = r_id_idx;
        w_cipo_next     = r_cipo;
        w_rd_en         = 1'b0;
        w_rd_addr       = r_addr;

        // Memory data arrives one cycle after the read; always well before the next SCK fall
        if (r_rd_pending) begin
            w_tx_shift_next = r_rd_data;
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next   = S_CMD;
                    w_bit_cnt_next = 3'd0;
                end
            end
            S_CMD: begin
                if (w_sck_rise) begin
                    w_rx_shift_next = w_rx_byte[6:0];
                    w_bit_cnt_next  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_cmd_next = w_rx_byte;
                        case (w_rx_byte)
                            8'h03: begin
                                w_state_next    = S_ADDR;
                                w_byte_cnt_next = 2'd0;
                            end
                            8'h05: begin
                                w_state_next    = S_DATA;
                                w_tx_shift_next = STATUS;
                            end
                            8'h9F: begin
                                w_state_next    = S_DATA;
                                w_tx_shift_next = JEDEC_ID[23:16];
                                w_id_idx_next   = 2'd1;
                            end
                            default: w_state_next = S_IGNORE;
                        endcase
                    end
                end
            end
            S_ADDR: begin
                if (w_sck_rise) begin
                    // Upper address bits fall off the top of the register
                    w_addr_next    = {r_addr[AW-2:0], w_copi_bit};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_cnt_next = r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd2) begin
                            w_rd_en      = 1'b1;
                            w_rd_addr    = w_addr_next;
                            w_state_next = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_sck_fall) begin
                    w_cipo_next     = r_tx_shift[7];
                    w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                end
                if (w_sck_rise) begin
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_cmd)
                            8'h03: begin
                                w_addr_next = r_addr + ADDR_ONE;
                                w_rd_en     = 1'b1;
                                w_rd_addr   = r_addr + ADDR_ONE;
                            end
                            8'h9F: begin
                                case (r_id_idx)
                                    2'd1:    w_tx_shift_next = JEDEC_ID[15:8];
                                    2'd2:    w_tx_shift_next = JEDEC_ID[7:0];
                                    default: w_tx_shift_next = 8'h00;
                                endcase
                                if (r_id_idx != 2'd3) begin
                                    w_id_idx_next = r_id_idx + 2'd1;
                                end
                            end
                            default: w_tx_shift_next = STATUS;
                        endcase
                    end
                end
            end
            S_IGNORE: begin
                w_state_next = S_IGNORE;
            end
            default: w_state_next = S_IDLE;
        endcase

        // Deselect aborts whatever is in progress
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
        end
    end

    assign o_cipo    = r_cipo;
    assign o_cipo_oe = (r_state == S_DATA);
    assign o_cmd     = r_cmd;
    assign o_active  = r_active;

endmodule

// File: tb/tb_spi_flash_target.sv
// Testbench for spi_flash_target: table-driven directed transfers, hand-written
// abort / collision / reset sequences, then randomized transfers against a
// byte-array reference of the flash.
module tb_spi_flash_target;

    localparam int HALF = 4;  // i_clk cycles per SCK phase

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_cs;
    logic       i_sclk;
    logic       i_copi;
    logic       o_cipo;
    logic       o_cipo_oe;
    logic       i_wr;
    logic [7:0] i_waddr;
    logic [7:0] i_wdata;
    logic [7:0] o_cmd;
    logic       o_active;

    spi_flash_target #(
        .MEM_DEPTH (256),
        .JEDEC_ID  (24'hC84015),
        .STATUS    (8'h00)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_cs      (i_cs),
        .i_sclk    (i_sclk),
        .i_copi    (i_copi),
        .o_cipo    (o_cipo),
        .o_cipo_oe (o_cipo_oe),
        .i_wr      (i_wr),
        .i_waddr   (i_waddr),
        .i_wdata   (i_wdata),
        .o_cmd     (o_cmd),
        .o_active  (o_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nrd;
        logic [31:0] exp_data;
        logic        exp_oe;
        logic        pre_abort;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] model_mem [256];
    logic [7:0] rd_buf [8];
    logic       oe_seen;
    logic       oe_end;
    logic       active_end;
    int         n_pass = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_cipo_oe) oe_seen = 1'b1;
        end
    endtask

    // Clock nb bits MSB-first from tx[7]; CIPO captured just before each rise.
    // With collide set, a host write of mem[20h]=77h lands on the same edge
    // the target decodes the final rise.
    task automatic spi_bits(input logic [7:0] tx, input int nb, input bit collide,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nb; b--) begin
            i_copi = tx[b];
            wait_neg(HALF);
            rx[b]  = o_cipo;
            i_sclk = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk);
                if (o_cipo_oe) oe_seen = 1'b1;
                if (collide && b == 7 - nb + 1 && k == 1) begin
                    i_wr = 1'b1; i_waddr = 8'h20; i_wdata = 8'h77;
                end
                if (k == 2) i_wr = 1'b0;
            end
            i_sclk = 1'b0;
        end
    endtask

    task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] addr,
                           input int nrd, input bit collide);
        logic [7:0] rx;
        i_cs = 1'b0;
        wait_neg(HALF);
        oe_seen = 1'b0;
        spi_bits(cmd, 8, 1'b0, rx);
        if (cmd == 8'h03) begin
            spi_bits(addr[23:16], 8, 1'b0, rx);
            spi_bits(addr[15:8],  8, 1'b0, rx);
            spi_bits(addr[7:0],   8, collide, rx);
        end
        for (int i = 0; i < nrd; i++) begin
            spi_bits(8'h00, 8, 1'b0, rx);
            rd_buf[i] = rx;
        end
        wait_neg(HALF);
        oe_end     = o_cipo_oe;
        active_end = o_active;
        i_cs = 1'b1;
        wait_neg(6);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        i_wr = 1'b1; i_waddr = a; i_wdata = d;
        @(negedge clk);
        i_wr = 1'b0;
        model_mem[a] = d;
    endtask

    // Reference: what a read-only NOR flash returns for byte idx of a transfer
    function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr,
                                              input int idx);
        logic [23:0] id;
        id = 24'hC84015;
        if (cmd == 8'h03) return model_mem[(int'(addr[7:0]) + idx) % 256];
        if (cmd == 8'h9F) return (idx < 3) ? 8'(id >> (8 * (2 - idx))) : 8'h00;
        return 8'h00;
    endfunction

    initial begin
        logic [7:0]  rx;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nrd;
        int          kind;

        vecs[0] = '{cmd: 8'h9F, addr: 24'h000000, nrd: 4, exp_data: 32'hC8401500, exp_oe: 1'b1, pre_abort: 1'b0};
        vecs[1] = '{cmd: 8'h03, addr: 24'h0000FE, nrd: 4, exp_data: 32'h5B5AA5A4, exp_oe: 1'b1, pre_abort: 1'b0};
        vecs[2] = '{cmd: 8'h05, addr: 24'h000000, nrd: 2, exp_data: 32'h00000000, exp_oe: 1'b1, pre_abort: 1'b0};
        vecs[3] = '{cmd: 8'h0B, addr: 24'h000000, nrd: 4, exp_data: 32'h00000000, exp_oe: 1'b0, pre_abort: 1'b0};
        vecs[4] = '{cmd: 8'h03, addr: 24'h000010, nrd: 1, exp_data: 32'hB5000000, exp_oe: 1'b1, pre_abort: 1'b1};
        vecs[5] = '{cmd: 8'h03, addr: 24'h123480, nrd: 2, exp_data: 32'h25240000, exp_oe: 1'b1, pre_abort: 1'b0};

        i_rst = 1'b1; i_cs = 1'b1; i_sclk = 1'b0; i_copi = 1'b0;
        i_wr = 1'b0; i_waddr = 8'h00; i_wdata = 8'h00; oe_seen = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_cipo",   o_cipo,    1'b0);
        check("rst_oe",     o_cipo_oe, 1'b0);
        check("rst_cmd",    o_cmd,     8'h00);
        check("rst_active", o_active,  1'b0);

        for (int i = 0; i < 256; i++) host_write(8'(i), 8'(i) ^ 8'hA5);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pre_abort) begin
                i_cs = 1'b0;
                wait_neg(HALF);
                spi_bits(8'h03, 8, 1'b0, rx);
                spi_bits(8'h00, 8, 1'b0, rx);
                spi_bits(8'hFF, 4, 1'b0, rx);
                wait_neg(HALF);
                i_cs = 1'b1;
                wait_neg(6);
                check("abort_oe", o_cipo_oe, 1'b0);
            end
            spi_txn(vecs[v].cmd, vecs[v].addr, vecs[v].nrd, 1'b0);
            if (vecs[v].exp_oe) begin
                for (int j = 0; j < vecs[v].nrd; j++)
                    check($sformatf("vec%0d_byte%0d", v, j), rd_buf[j], vecs[v].exp_data[31 - 8 * j -: 8]);
                check($sformatf("vec%0d_oe", v), oe_end, 1'b1);
                check($sformatf("vec%0d_active", v), active_end, 1'b1);
            end else begin
                check($sformatf("vec%0d_oe_quiet", v), oe_seen, 1'b0);
            end
            check($sformatf("vec%0d_cmd", v), o_cmd, vecs[v].cmd);
            $display("txn vec%0d cmd=%02h addr=%06h n=%0d", v, vecs[v].cmd, vecs[v].addr, vecs[v].nrd);
        end
        check("idle_oe", o_cipo_oe, 1'b0);
        check("idle_active", o_active, 1'b0);

        // Host write colliding with the memory read of the same address
        spi_txn(8'h03, 24'h000020, 1, 1'b1);
        model_mem[8'h20] = 8'h77;
        check("collide_old", rd_buf[0], 8'h85);
        $display("txn collide cmd=03 addr=000020 data=%02h", rd_buf[0]);
        spi_txn(8'h03, 24'h000020, 1, 1'b0);
        check("collide_new", rd_buf[0], 8'h77);
        $display("txn reread cmd=03 addr=000020 data=%02h", rd_buf[0]);

        // Reset in the middle of a JEDEC data byte
        i_cs = 1'b0;
        wait_neg(HALF);
        spi_bits(8'h9F, 8, 1'b0, rx);
        spi_bits(8'h00, 1, 1'b0, rx);
        check("mid_msb", rx[7], 1'b1);
        wait_neg(HALF);
        check("pre_rst_cipo", o_cipo, 1'b1);
        check("pre_rst_oe", o_cipo_oe, 1'b1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("post_rst_oe", o_cipo_oe, 1'b0);
        check("post_rst_cipo", o_cipo, 1'b0);
        i_cs = 1'b1;
        wait_neg(8);
        spi_txn(8'h9F, 24'h0, 3, 1'b0);
        check("rerun_id0", rd_buf[0], 8'hC8);
        check("rerun_id1", rd_buf[1], 8'h40);
        check("rerun_id2", rd_buf[2], 8'h15);
        $display("txn after_reset cmd=9F data=%02h%02h%02h", rd_buf[0], rd_buf[1], rd_buf[2]);

        // Randomized transfers against the reference
        for (int t = 0; t < 30; t++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                host_write(8'($urandom_range(0, 255)), 8'($urandom));
            kind = int'($urandom_range(0, 3));
            addr = 24'($urandom);
            if ($urandom_range(0, 2) == 0) addr[7:0] = 8'hFC + 8'($urandom_range(0, 3));
            nrd  = int'($urandom_range(1, 5));
            case (kind)
                0: cmd = 8'h03;
                1: cmd = 8'h05;
                2: cmd = 8'h9F;
                default: begin
                    cmd = 8'($urandom);
                    while (cmd == 8'h03 || cmd == 8'h05 || cmd == 8'h9F) cmd = cmd + 8'd1;
                end
            endcase
            spi_txn(cmd, addr, nrd, 1'b0);
            if (kind < 3) begin
                for (int j = 0; j < nrd; j++)
                    check($sformatf("rnd%0d_byte%0d", t, j), rd_buf[j], model_byte(cmd, addr, j));
            end else begin
                check($sformatf("rnd%0d_oe_quiet", t), oe_seen, 1'b0);
            end
            check($sformatf("rnd%0d_cmd", t), o_cmd, cmd);
            $display("txn rnd%0d cmd=%02h addr=%06h n=%0d first=%02h", t, cmd, addr, nrd, rd_buf[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
